factor_sequencer: RTL

Control sequencer for the factorizer datapath. It watches the 8-bit operand from the input switches and launches the factorizer with a start/done handshake whenever the operand changes. It latches the returned factor vector and steps the display digit through 1 and every factor 2..15, holding each digit for a programmable dwell. It replaces the ad-hoc free-running counter/skip logic in the top level with an explicit FSM, bounded wait and error reporting.

---
 rtl/factor_sequencer_if.sv | 39 +++
 rtl/factor_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/factor_sequencer_if.sv
// ----------------------------------------------------------------------------
// factor_sequencer_if
//
// Start/done handshake between the factor sequencer and the factorizer
// datapath.
//
//   fz_start    one-cycle launch pulse (sequencer -> factorizer)
//   fz_number   8-bit operand of the current/last launch, held stable
//               from the launch onwards (sequencer -> factorizer)
//   fz_done     single-cycle result-valid pulse (factorizer -> sequencer)
//   fz_factors  18-bit result: bit i set means (i+2) divides fz_number
//               (factorizer -> sequencer)
//
// Modports:
//   master  sequencer side
//   slave   factorizer side
// ----------------------------------------------------------------------------
interface factor_sequencer_if;

    logic        fz_start;
    logic [7:0]  fz_number;
    logic        fz_done;
    logic [17:0] fz_factors;

    modport master (
        output fz_start,
        output fz_number,
        input  fz_done,
        input  fz_factors
    );

    modport slave (
        input  fz_start,
        input  fz_number,
        output fz_done,
        output fz_factors
    );

endinterface

// File: rtl/factor_sequencer.sv
// ----------------------------------------------------------------------------
// factor_sequencer
//
// Control sequencer for the factorizer datapath. It watches the switch
// operand, launches the factorizer whenever the operand differs from the
// last launched one, latches the returned factor vector and steps the
// display digit through 1 and every displayable factor 2..15, holding each
// digit for DWELL cycles. A launch that sees no fz_done within TIMEOUT
// cycles of waiting is reported as an error (digit E) until the operand
// changes.
//
// Parameters:
//   DWELL    cycles each digit is held, 1..2^24-1
//   TIMEOUT  maximum WAIT cycles for fz_done, 1..255
//
// Ports:
//   clk          single clock, all state on the rising edge
//   reset        synchronous, active-high
//   number       8-bit operand from the switches, sampled every cycle
//   fz           factorizer handshake (master side): fz_start, fz_number
//                out; fz_done, fz_factors in
//   factors_q    latched factor vector of the last completed run
//   digit        value for the seven-segment decoder
//   digit_valid  digit is meaningful (SHOW or ERROR)
//   busy         high in START and WAIT
//   error        high in ERROR
//
// All outputs are registered: each one is computed from the next state and
// loaded on the same edge as the state register.
// ----------------------------------------------------------------------------
module factor_sequencer #(
    parameter logic [23:0] DWELL   = 24'd10_000_000,
    parameter logic [7:0]  TIMEOUT = 8'd64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                number,
    factor_sequencer_if.master        fz,
    output logic [17:0]               factors_q,
    output logic [3:0]                digit,
    output logic                      digit_valid,
    output logic                      busy,
    output logic                      error
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SHOW  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [3:0] DIGIT_ERR = 4'hE;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  state;
    logic        launch_pending;
    logic [23:0] dwell_cnt;
    logic [7:0]  timeout_cnt;

    // Next-state values
    logic [2:0]  state_n;
    logic        launch_pending_n;
    logic [23:0] dwell_cnt_n;
    logic [7:0]  timeout_cnt_n;
    logic [7:0]  fz_number_n;
    logic [17:0] factors_q_n;
    logic [3:0]  digit_n;
    logic        fz_start_n;
    logic        digit_valid_n;
    logic        busy_n;
    logic        error_n;

    logic        change;
    logic [3:0]  next_digit;
    logic        next_found;

    // Operand differs from the one last handed to the factorizer.
    assign change = (number != fz.fz_number);

    // ------------------------------------------------------------------
    // Next displayable digit: smallest d in (digit+1)..15 whose factor
    // bit is set, otherwise wrap back to 1. Factor bits 14..17 (16..19)
    // cannot be shown on a single hex digit and are never searched.
    // ------------------------------------------------------------------
    always_comb begin
        next_digit = 4'd1;
        next_found = 1'b0;
        for (int unsigned d = 2; d <= 15; d++) begin
            if (!next_found && (d > 32'(digit)) && factors_q[d - 2]) begin
                next_digit = 4'(d);
                next_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer transitions
    // ------------------------------------------------------------------
    always_comb begin
        state_n          = state;
        launch_pending_n = launch_pending;
        dwell_cnt_n      = dwell_cnt;
        timeout_cnt_n    = timeout_cnt;
        fz_number_n      = fz.fz_number;
        factors_q_n      = factors_q;
        digit_n          = digit;

        case (state)
            ST_IDLE: begin
                // launch_pending forces a first launch after reset even
                // when the switches read the reset operand of 0.
                if (launch_pending || change) begin
                    state_n     = ST_START;
                    fz_number_n = number;
                end
                launch_pending_n = 1'b0;
            end

            ST_START: begin
                // Operand changes here are not looked at; WAIT catches
                // them one cycle later and relaunches.
                state_n       = ST_WAIT;
                timeout_cnt_n = '0;
            end

            ST_WAIT: begin
                if (change) begin
                    // A result arriving in the same cycle belongs to the
                    // superseded operand and is dropped.
                    state_n     = ST_START;
                    fz_number_n = number;
                end else if (fz.fz_done) begin
                    state_n     = ST_SHOW;
                    factors_q_n = fz.fz_factors;
                    digit_n     = 4'd1;
                    dwell_cnt_n = '0;
                end else if (timeout_cnt == TIMEOUT - 8'd1) begin
                    state_n = ST_ERROR;
                end else begin
                    timeout_cnt_n = timeout_cnt + 8'd1;
                end
            end

            ST_SHOW: begin
                if (change) begin
                    state_n     = ST_START;
                    fz_number_n = number;
                end else if (dwell_cnt == DWELL - 24'd1) begin
                    // With no displayable factor the search returns 1,
                    // so the digit stays at 1 and the dwell restarts.
                    dwell_cnt_n = '0;
                    digit_n     = next_digit;
                end else begin
                    dwell_cnt_n = dwell_cnt + 24'd1;
                end
            end

            ST_ERROR: begin
                if (change) begin
                    state_n     = ST_START;
                    fz_number_n = number;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        case (state_n)
            ST_SHOW:  ;
            ST_ERROR: digit_n = DIGIT_ERR;
            default:  digit_n = '0;
        endcase

        fz_start_n    = (state_n == ST_START);
        busy_n        = (state_n == ST_START) || (state_n == ST_WAIT);
        digit_valid_n = (state_n == ST_SHOW)  || (state_n == ST_ERROR);
        error_n       = (state_n == ST_ERROR);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            launch_pending <= 1'b1;
            dwell_cnt      <= '0;
            timeout_cnt    <= '0;
            fz.fz_start    <= 1'b0;
            fz.fz_number   <= '0;
            factors_q      <= '0;
            digit          <= '0;
            digit_valid    <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_n;
            launch_pending <= launch_pending_n;
            dwell_cnt      <= dwell_cnt_n;
            timeout_cnt    <= timeout_cnt_n;
            fz.fz_start    <= fz_start_n;
            fz.fz_number   <= fz_number_n;
            factors_q      <= factors_q_n;
            digit          <= digit_n;
            digit_valid    <= digit_valid_n;
            busy           <= busy_n;
            error          <= error_n;
        end
    end

endmodule
